// File: rtl/scanline_pkg.sv
// Shared types and constants for the scanline darkening controller.
package scanline_pkg;

    typedef enum logic [1:0] {SCAN_OFF, SCAN_25, SCAN_50, SCAN_75} scan_mode_t;
    typedef enum logic [1:0] {IDLE, PENDING, COMMIT} ctrl_state_t;

    localparam int PERIOD_MIN = 2;
    localparam int PHASE_W    = 3;

    // Keep the dark line inside the period so it is always reachable.
    function automatic logic [PHASE_W-1:0] clamp_phase(input logic [PHASE_W-1:0] ph,
                                                       input logic [PHASE_W-1:0] p);
        return (ph >= p) ? p - PHASE_W'(1) : ph;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers a sync input and flags its falling edge for one cycle.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    output logic fall_o
);

    logic old_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) old_q <= 1'b0;
        else       old_q <= sync_i;
    end

    assign fall_o = old_q & ~sync_i;

endmodule

// File: rtl/scanline_ctrl.sv
// Per-line darkening level sequencer with frame-synchronous config handover.
// Optional SCANLINE_CTRL_ALT_FIELD_EN shifts the dark line by one every frame.
module scanline_ctrl
    import scanline_pkg::*;
#(
    parameter int         TIMEOUT_W  = 22,
    parameter logic [1:0] RESET_MODE = 2'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_mode,
    input  logic [1:0] cfg_period,
    input  logic [2:0] cfg_phase,
    input  logic       hs_in,
    input  logic       vs_in,
    output logic [1:0] level,
    output logic [1:0] active_mode,
    output logic       pending,
    output logic       timeout_err
);

    logic hs_fall, vs_fall;

    sync_edge_det u_hs (.clk(clk), .reset(reset), .sync_i(hs_in), .fall_o(hs_fall));
    sync_edge_det u_vs (.clk(clk), .reset(reset), .sync_i(vs_in), .fall_o(vs_fall));

    ctrl_state_t          state_q;
    scan_mode_t           sh_mode_q, mode_q;
    logic [1:0]           sh_period_q;
    logic [PHASE_W-1:0]   sh_phase_q, sh_per, sh_ph;
    logic [PHASE_W-1:0]   per_q, phase_q;
    logic [TIMEOUT_W-1:0] wd_q, wd_inc;
    logic                 ready_q, pend_q, terr_q;

    assign sh_per = PHASE_W'(sh_period_q) + PHASE_W'(PERIOD_MIN);
    assign sh_ph  = clamp_phase(sh_phase_q, sh_per);
    assign wd_inc = wd_q + TIMEOUT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_mode_q   <= SCAN_OFF;
            sh_period_q <= '0;
            sh_phase_q  <= '0;
            mode_q      <= scan_mode_t'(RESET_MODE);
            per_q       <= PHASE_W'(PERIOD_MIN);
            phase_q     <= '0;
            wd_q        <= '0;
            ready_q     <= 1'b1;
            pend_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        sh_mode_q   <= scan_mode_t'(cfg_mode);
                        sh_period_q <= cfg_period;
                        sh_phase_q  <= cfg_phase;
                        wd_q        <= '0;
                        ready_q     <= 1'b0;
                        pend_q      <= 1'b1;
                        state_q     <= PENDING;
                    end
                end
                PENDING: begin
                    wd_q <= wd_inc;
                    if (vs_fall) begin
                        state_q <= COMMIT;
                    end else if (&wd_inc) begin
                        // Video stalled: force the commit rather than hold the host off forever.
                        state_q <= COMMIT;
                        terr_q  <= 1'b1;
                    end
                end
                COMMIT: begin
                    mode_q  <= sh_mode_q;
                    per_q   <= sh_per;
                    phase_q <= sh_ph;
                    wd_q    <= '0;
                    pend_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [PHASE_W-1:0] line_q, line_d, lvl_phase, eff_phase;
    scan_mode_t         lvl_mode;
    logic [1:0]         level_q, level_d;
`ifdef SCANLINE_CTRL_ALT_FIELD_EN
    logic               frame_q, frame_d;
    logic [PHASE_W-1:0] lvl_per, ph_sum;
`endif

    // During COMMIT the level is recomputed from the shadow values about to go live.
    always_comb begin
        lvl_mode  = mode_q;
        lvl_phase = phase_q;
        if (state_q == COMMIT) begin
            lvl_mode  = sh_mode_q;
            lvl_phase = sh_ph;
        end
        line_d = line_q;
        if (vs_fall)
            line_d = '0;
        else if (hs_fall)
            line_d = (line_q >= per_q - PHASE_W'(1)) ? '0 : line_q + PHASE_W'(1);
`ifdef SCANLINE_CTRL_ALT_FIELD_EN
        lvl_per   = (state_q == COMMIT) ? sh_per : per_q;
        frame_d   = frame_q ^ vs_fall;
        ph_sum    = lvl_phase + PHASE_W'(frame_d);
        eff_phase = (ph_sum >= lvl_per) ? ph_sum - lvl_per : ph_sum;
`else
        eff_phase = lvl_phase;
`endif
        level_d = (line_d == eff_phase && lvl_mode != SCAN_OFF) ? lvl_mode : 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q  <= '0;
            level_q <= 2'd0;
`ifdef SCANLINE_CTRL_ALT_FIELD_EN
            frame_q <= 1'b0;
`endif
        end else begin
            line_q <= line_d;
`ifdef SCANLINE_CTRL_ALT_FIELD_EN
            frame_q <= frame_d;
`endif
            if (hs_fall || vs_fall || state_q == COMMIT)
                level_q <= level_d;
        end
    end

    assign level       = level_q;
    assign active_mode = mode_q;
    assign pending     = pend_q;
    assign cfg_ready   = ready_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_scanline_ctrl.sv
// Directed self-checking bench for scanline_ctrl (watchdog shortened to 15 cycles).
module tb_scanline_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_mode = '0;
    logic [1:0] cfg_period = '0;
    logic [2:0] cfg_phase = '0;
    logic       hs_in = 1'b0;
    logic       vs_in = 1'b0;
    logic [1:0] level;
    logic [1:0] active_mode;
    logic       pending;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    bit tb_frame = 1'b0;

    scanline_ctrl #(.TIMEOUT_W(4), .RESET_MODE(2'd0)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_phase(cfg_phase),
        .hs_in(hs_in), .vs_in(vs_in),
        .level(level), .active_mode(active_mode),
        .pending(pending), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected level for a line; alternate-field builds rotate the dark line by frame parity.
    function automatic int exp_lvl(input int mode, input int p, input int ph, input int line);
        int eff;
        eff = ph;
`ifdef SCANLINE_CTRL_ALT_FIELD_EN
        eff = (ph + int'(tb_frame)) % p;
`endif
        return (line == eff && mode != 0) ? mode : 0;
    endfunction

    task automatic hline();
        hs_in = 1'b1; tick();
        hs_in = 1'b0; tick();
        tick(); tick();
    endtask

    task automatic vsync();
        vs_in = 1'b1; tick();
        vs_in = 1'b0; tick();
        tb_frame = ~tb_frame;
        tick(); tick();
    endtask

    task automatic write(input logic [1:0] m, input logic [1:0] p, input logic [2:0] ph);
        cfg_valid = 1'b1; cfg_mode = m; cfg_period = p; cfg_phase = ph;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        tick(); tick();
        chk("rst_level", level, 0);
        chk("rst_mode", active_mode, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_terr", timeout_err, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            hline();
            chk("idle_level", level, 0);
        end
        chk("idle_mode", active_mode, 0);
        chk("idle_ready", cfg_ready, 1);

        write(2'd2, 2'd0, 3'd1);
        chk("p2_pending", pending, 1);
        chk("p2_ready", cfg_ready, 0);
        hline();
        chk("p2_still_pending", pending, 1);
        chk("p2_old_mode", active_mode, 0);
        vsync();
        chk("p2_pend_clr", pending, 0);
        chk("p2_ready_back", cfg_ready, 1);
        chk("p2_mode", active_mode, 2);
        chk("p2_line0", level, exp_lvl(2, 2, 1, 0));
        for (int i = 1; i < 6; i++) begin
            hline();
            chk("p2_line", level, exp_lvl(2, 2, 1, i % 2));
        end

        write(2'd1, 2'd0, 3'd0);
        write(2'd3, 2'd1, 3'd2);
        chk("ign_pending", pending, 1);
        vsync();
        chk("ign_mode", active_mode, 1);
        for (int f = 0; f < 2; f++) begin
            if (f == 1) vsync();
            chk("alt_line0", level, exp_lvl(1, 2, 0, 0));
            for (int i = 1; i < 6; i++) begin
                hline();
                chk("alt_line", level, exp_lvl(1, 2, 0, i % 2));
            end
        end

        write(2'd3, 2'd2, 3'd6);
        vsync();
        chk("clamp_mode", active_mode, 3);
        chk("clamp_line0", level, exp_lvl(3, 4, 3, 0));
        for (int i = 1; i < 8; i++) begin
            hline();
            chk("clamp_line", level, exp_lvl(3, 4, 3, i % 4));
        end

        hline(); hline(); hline();
        chk("pre_coinc", level, exp_lvl(3, 4, 3, 2));
        hs_in = 1'b1; vs_in = 1'b1; tick();
        hs_in = 1'b0; vs_in = 1'b0; tick();
        tb_frame = ~tb_frame;
        tick();
        chk("coinc_line0", level, exp_lvl(3, 4, 3, 0));
        for (int i = 1; i < 4; i++) begin
            hline();
            chk("coinc_line", level, exp_lvl(3, 4, 3, i));
        end

        vs_in = 1'b1; tick();
        vs_in = 1'b0;
        cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_period = 2'd0; cfg_phase = 3'd0;
        tick();
        cfg_valid = 1'b0;
        tb_frame = ~tb_frame;
        tick(); tick();
        chk("vsv_pending", pending, 1);
        chk("vsv_mode_held", active_mode, 3);
        vsync();
        chk("vsv_mode", active_mode, 2);
        chk("vsv_pend_clr", pending, 0);
        chk("vsv_line0", level, exp_lvl(2, 2, 0, 0));
        chk("pre_to_terr", timeout_err, 0);

        write(2'd1, 2'd1, 3'd0);
        n = 0;
        while (pending === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 16);
        chk("to_ready", cfg_ready, 1);
        chk("to_terr", timeout_err, 1);
        chk("to_mode", active_mode, 1);

        write(2'd2, 2'd0, 3'd0);
        vsync();
        chk("terr_sticky", timeout_err, 1);
        chk("sticky_mode", active_mode, 2);

        write(2'd3, 2'd0, 3'd0);
        tick(); tick();
        chk("mid_pending", pending, 1);
        reset = 1'b1;
        #1;
        chk("arst_pending", pending, 0);
        chk("arst_mode", active_mode, 0);
        chk("arst_ready", cfg_ready, 1);
        chk("arst_terr", timeout_err, 0);
        chk("arst_level", level, 0);
        tb_frame = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scanline_ctrl.md
Name: scanline_ctrl

Overview:
- Controller that sequences the per-line darkening level for the scanline datapath and safely hands over host configuration.
- Host writes mode/period/phase over a valid/ready handshake. The block shadows the write and commits it only at frame start (vs falling edge), or on a watchdog timeout if video is stalled.
- Per line it outputs a 2-bit level: 0 = pass, 1 = -25%, 2 = -50%, 3 = -75%. The level is consumed by the datapath in place of its free-running scanline counter.

Parameters:
- TIMEOUT_W, 22, width of the pending-commit watchdog counter; timeout = 2^TIMEOUT_W - 1 cycles.
- RESET_MODE, 2'd0, active mode after reset.

Ports:
- clk  in  1  video/pixel clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  host config write request
- cfg_ready  out  1  high when the controller can accept a config
- cfg_mode  in  2  darkening level for dark lines (0 disables)
- cfg_period  in  2  pattern period P = cfg_period + 2 lines (2..5)
- cfg_phase  in  3  index of the dark line within the period
- hs_in  in  1  horizontal sync, active-high
- vs_in  in  1  vertical sync, active-high
- level  out  2  level for the current line
- active_mode  out  2  committed mode
- pending  out  1  shadow config awaiting commit
- timeout_err  out  1  sticky; set when a commit was forced by the watchdog

Behaviour:
- Reset (async): level=0, active_mode=RESET_MODE, active period=2, active phase=0, line_cnt=0, frame=0, pending=0, cfg_ready=1, timeout_err=0, watchdog=0, state=IDLE. The edge-detect registers old_hs and old_vs reset to 0.
- Edge detect: hs_fall = old_hs & ~hs_in; vs_fall = old_vs & ~vs_in. old_* are registered each cycle.
- FSM IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch mode, period and phase into the shadow registers, then go to PENDING.
  - If cfg_valid and vs_fall occur in the same cycle, the latch still goes to PENDING; the commit waits for the next vs_fall.
- FSM PENDING:
  - cfg_ready=0, pending=1, watchdog increments each cycle.
  - On vs_fall, go to COMMIT.
  - If watchdog reaches all-ones, go to COMMIT and set timeout_err.
  - cfg_valid is ignored in this state.
- FSM COMMIT (1 cycle):
  - Copy shadow to active. If phase >= P, clamp phase to P-1.
  - Clear watchdog and pending, then go to IDLE. cfg_ready returns high the following cycle.
- Line sequencing:
  - On vs_fall: line_cnt <= 0 and frame toggles.
  - Else on hs_fall: line_cnt <= (line_cnt == P-1) ? 0 : line_cnt+1, where P is the active period.
  - vs_fall has priority over a coincident hs_fall.
- Level:
  - Registered: level <= (line_cnt_next == eff_phase && active_mode != 0) ? active_mode : 0.
  - Level updates on the clock edge where hs_fall or vs_fall is detected. Latency is one cycle after the falling sync sample.
  - A config committed at vs_fall takes effect from line 0 of the new frame. The COMMIT cycle recomputes level with the new values.
- Arithmetic: line_cnt is 3 bits. eff_phase is 3 bits. P is compared as 3 bits. No wrap beyond 4.
- timeout_err is cleared only by reset.

Optional Feature:
- Macro SCANLINE_CTRL_ALT_FIELD_EN.
- Defined: eff_phase = (phase + frame) mod P, so the dark line shifts by one each frame to reduce static flicker on interlaced/CRT output.
- Not defined: eff_phase = phase, and the frame register may be optimised away.

Decomposition:
- Shared package scanline_pkg:
  - enum scan_mode_t {SCAN_OFF, SCAN_25, SCAN_50, SCAN_75}
  - enum ctrl_state_t {IDLE, PENDING, COMMIT}
  - constants PERIOD_MIN=2 and PHASE_W=3
- One natural sub-module, sync_edge_det: registers a sync input and outputs its fall pulse. Instantiated twice, for hs and vs.

Test Plan:
- Reset with no config, drive 10 lines -> level=0 on every line; active_mode=0; cfg_ready=1.
- Write mode=2, period=0, phase=1 mid-frame -> pending=1 and cfg_ready=0 until the next vs_fall. Then level on lines 0..5 is 0,2,0,2,0,2.
- Write mode=3, period=2 (P=4), phase=6 -> phase clamps to 3. Across lines 0..7 after commit, level is 0,0,0,3,0,0,0,3.
- Hold vs_in low after a write with TIMEOUT_W=4 -> commit after 15 cycles; timeout_err=1; cfg_ready=1 one cycle after COMMIT.
- hs_fall and vs_fall in the same cycle -> line_cnt=0, not 1; level reflects phase vs line 0.
- With SCANLINE_CTRL_ALT_FIELD_EN, mode=1, P=2, phase=0 -> frame 0 dark lines 0,2,4; frame 1 dark lines 1,3,5. Assert reset mid-PENDING -> pending=0 and active_mode=RESET_MODE.
